// File: rtl/i2s_audio_serializer.sv
// I2S master serializer: pops one {left, right} word per frame from a
// first-word-fall-through FIFO and shifts it out MSB first on i2s_data,
// generating i2s_bclk and i2s_wclk from clk.
//
// Handshake: fifo_rd is a registered one-cycle pop strobe. It is raised only
// when fifo_empty was low at the deciding edge, and the word shown on
// fifo_data at that edge is the word taken. The FIFO must retire its head at
// the end of the strobe cycle. There is no back-pressure toward the FIFO
// beyond fifo_empty.
module i2s_audio_serializer #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [2*SAMPLE_WIDTH-1:0] fifo_data,
    input  logic                      fifo_empty,
    output logic                      fifo_rd,
    output logic                      i2s_bclk,
    output logic                      i2s_wclk,
    output logic                      i2s_data,
    output logic                      busy,
    output logic                      frame_start,
    output logic                      underrun
);

    localparam int FW    = 2 * SAMPLE_WIDTH;
    localparam int NSLOT = 2 * SLOT_WIDTH;
    localparam int SN    = $clog2(NSLOT);
    localparam int DW    = $clog2(BCLK_DIV);

    localparam logic [SN-1:0] LAST_SLOT     = SN'(NSLOT - 1);
    localparam logic [SN-1:0] FETCH_PREV    = SN'(SLOT_WIDTH + SAMPLE_WIDTH - 1);
    localparam logic [SN-1:0] WCLK_HI_FIRST = SN'(SLOT_WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST      = DW'(BCLK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t           r_state;
    logic [DW-1:0]    r_div;
    logic [SN-1:0]    r_slot;
    logic [NSLOT-1:0] r_shift;
    logic [FW-1:0]    r_next;
    logic             r_stop;
    logic             r_fifo_rd;
    logic             r_bclk;
    logic             r_wclk;
    logic             r_data;
    logic             r_busy;
    logic             r_frame_start;
    logic             r_underrun;

    logic [NSLOT-1:0] w_fifo_frame;
    logic [NSLOT-1:0] w_next_frame;
    logic [SN-1:0]    w_slot_inc;
    logic             w_wclk_next;

    // Lay a stereo word out as the whole frame bit sequence, slot 0 at the MSB:
    // left MSB-first, zero pad, right MSB-first, zero pad.
    function automatic logic [NSLOT-1:0] frame_bits(input logic [FW-1:0] s);
        return {s[FW-1:SAMPLE_WIDTH], {(SLOT_WIDTH - SAMPLE_WIDTH){1'b0}},
                s[SAMPLE_WIDTH-1:0],  {(SLOT_WIDTH - SAMPLE_WIDTH){1'b0}}};
    endfunction

    assign w_fifo_frame = frame_bits(fifo_data);
    assign w_next_frame = frame_bits(r_next);
    assign w_slot_inc   = r_slot + 1'b1;
    // WCLK leads the channel MSB by one BCLK: high from slot SLOT_WIDTH-1 up to
    // but not including the last slot.
    assign w_wclk_next  = (w_slot_inc >= WCLK_HI_FIRST) && (w_slot_inc != LAST_SLOT);

    // Control FSM, clock dividers, slot counter and serial shifter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_div         <= '0;
            r_slot        <= '0;
            r_shift       <= '0;
            r_next        <= '0;
            r_stop        <= 1'b0;
            r_fifo_rd     <= 1'b0;
            r_bclk        <= 1'b0;
            r_wclk        <= 1'b0;
            r_data        <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_fifo_rd     <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_bclk <= 1'b0;
                    r_wclk <= 1'b0;
                    r_data <= 1'b0;
                    r_div  <= '0;
                    r_slot <= '0;
                    r_stop <= 1'b0;
                    if (enable) begin
                        r_state <= ST_PRIME;
                        r_busy  <= 1'b1;
                    end
                end
                ST_PRIME: begin
                    if (r_fifo_rd) begin
                        // First word taken last cycle: start slot 0 with its left MSB.
                        r_state       <= ST_RUN;
                        r_frame_start <= 1'b1;
                        r_div         <= '0;
                        r_slot        <= '0;
                        r_bclk        <= 1'b0;
                        r_wclk        <= 1'b0;
                        r_data        <= r_shift[NSLOT-1];
                    end else if (!enable) begin
                        // Nothing popped yet, so leaving here loses no data.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (!fifo_empty) begin
                        r_fifo_rd <= 1'b1;
                        r_shift   <= w_fifo_frame;
                    end
                end
                ST_RUN: begin
                    if (r_div != DIV_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_bclk) begin
                            r_bclk <= 1'b1;
                        end else begin
                            // BCLK falling edge: every output change happens here.
                            r_bclk <= 1'b0;
                            if (r_slot == LAST_SLOT) begin
                                if (r_stop) begin
                                    r_state <= ST_IDLE;
                                    r_busy  <= 1'b0;
                                    r_stop  <= 1'b0;
                                    r_slot  <= '0;
                                    r_wclk  <= 1'b0;
                                    r_data  <= 1'b0;
                                    r_shift <= '0;
                                    r_next  <= '0;
                                end else begin
                                    r_slot        <= '0;
                                    r_shift       <= w_next_frame;
                                    r_data        <= w_next_frame[NSLOT-1];
                                    r_wclk        <= 1'b0;
                                    r_frame_start <= 1'b1;
                                end
                            end else begin
                                r_slot  <= w_slot_inc;
                                r_shift <= {r_shift[NSLOT-2:0], 1'b0};
                                r_data  <= r_shift[NSLOT-2];
                                r_wclk  <= w_wclk_next;
                                // Fetch point: the only place enable is looked at while running.
                                if (r_slot == FETCH_PREV) begin
                                    if (!enable) begin
                                        r_stop <= 1'b1;
                                    end else if (!fifo_empty) begin
                                        r_fifo_rd <= 1'b1;
                                        r_next    <= fifo_data;
                                    end else begin
                                        r_next     <= '0;
                                        r_underrun <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd     = r_fifo_rd;
    assign i2s_bclk    = r_bclk;
    assign i2s_wclk    = r_wclk;
    assign i2s_data    = r_data;
    assign busy        = r_busy;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_i2s_audio_serializer.sv
// Directed bench for i2s_audio_serializer at BCLK_DIV=2 (frame = 256 clk).
module tb_i2s_audio_serializer;

    localparam int DIV   = 2;
    localparam int SW    = 24;
    localparam int SL    = 32;
    localparam int NS    = 2 * SL;
    localparam int PER   = 2 * DIV;
    localparam int FRAME = NS * PER;
    localparam int FETCH = (SL + SW) * PER;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [47:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        i2s_bclk;
    logic        i2s_wclk;
    logic        i2s_data;
    logic        busy;
    logic        frame_start;
    logic        underrun;

    i2s_audio_serializer #(
        .SAMPLE_WIDTH(SW),
        .SLOT_WIDTH  (SL),
        .BCLK_DIV    (DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .i2s_bclk   (i2s_bclk),
        .i2s_wclk   (i2s_wclk),
        .i2s_data   (i2s_data),
        .busy       (busy),
        .frame_start(frame_start),
        .underrun   (underrun)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- frame-level reference model ----------------
    typedef enum logic [1:0] {M_IDLE, M_PRIME, M_RUN} m_mode_t;
    m_mode_t     m_mode;
    int          m_ph;
    logic        m_popped;
    logic        m_stop;
    logic [47:0] m_cur;
    logic [47:0] m_next;
    logic        m_rd;
    logic        m_fs;
    logic        m_ur;

    // Model advances on the same edges as the DUT; outputs follow from m_ph.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= M_IDLE; m_ph <= 0; m_popped <= 1'b0; m_stop <= 1'b0;
            m_cur <= '0; m_next <= '0; m_rd <= 1'b0; m_fs <= 1'b0; m_ur <= 1'b0;
        end else begin
            m_rd <= 1'b0; m_fs <= 1'b0; m_ur <= 1'b0;
            case (m_mode)
                M_IDLE: if (enable) m_mode <= M_PRIME;
                M_PRIME: begin
                    if (m_popped) begin
                        m_mode <= M_RUN; m_ph <= 0; m_fs <= 1'b1; m_popped <= 1'b0;
                    end else if (!enable) begin
                        m_mode <= M_IDLE;
                    end else if (!fifo_empty) begin
                        m_rd <= 1'b1; m_cur <= fifo_data; m_popped <= 1'b1;
                    end
                end
                default: begin
                    if (m_ph == FRAME - 1) begin
                        if (m_stop) begin
                            m_mode <= M_IDLE; m_stop <= 1'b0; m_ph <= 0;
                        end else begin
                            m_ph <= 0; m_cur <= m_next; m_fs <= 1'b1;
                        end
                    end else begin
                        m_ph <= m_ph + 1;
                        if (m_ph == FETCH - 1) begin
                            if (!enable) m_stop <= 1'b1;
                            else if (!fifo_empty) begin m_rd <= 1'b1; m_next <= fifo_data; end
                            else begin m_next <= '0; m_ur <= 1'b1; end
                        end
                    end
                end
            endcase
        end
    end

    // ---------------- scoreboard / monitor state ----------------
    int          checks;
    int          failures;
    int          cyc;
    logic [47:0] fifo_q[$];
    logic        pop_owed;
    int          rd_cnt;
    int          ur_cnt;
    int          fs_t[$];
    int          rd_ph[$];
    int          br_t[$];
    logic [63:0] cap_d[$];
    logic [63:0] cap_w[$];
    logic [63:0] cur_d;
    logic [63:0] cur_w;
    int          cur_slot;
    logic        have_frame;
    logic        prev_bclk;
    logic        prev_busy;
    int          last_fs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic upd_pins();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 48'h0 : fifo_q[0];
    endtask

    task automatic clear_mon();
        rd_cnt = 0; ur_cnt = 0; have_frame = 1'b0; cur_slot = 0;
        fs_t.delete(); rd_ph.delete(); br_t.delete(); cap_d.delete(); cap_w.delete();
    endtask

    function automatic logic [63:0] frame_at(input int i);
        return (i < cap_d.size()) ? cap_d[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    // One clock step: compare against the model, record events, service the FIFO.
    task automatic tick();
        int         n;
        int         k;
        logic [23:0] ch;
        logic       e_bclk, e_wclk, e_data;
        logic [6:0] exp_v, act_v;
        @(negedge clk);
        cyc++;
        e_bclk = 1'b0; e_wclk = 1'b0; e_data = 1'b0;
        if (m_mode == M_RUN) begin
            n      = m_ph / PER;
            e_bclk = (m_ph % PER) >= DIV;
            e_wclk = ((n + 1) % NS) >= SL;
            k      = n % SL;
            ch     = (n < SL) ? m_cur[47:24] : m_cur[23:0];
            e_data = (k < SW) ? ch[SW-1-k] : 1'b0;
        end
        exp_v = {m_rd, e_bclk, e_wclk, e_data, (m_mode != M_IDLE), m_fs, m_ur};
        act_v = {fifo_rd, i2s_bclk, i2s_wclk, i2s_data, busy, frame_start, underrun};
        check("cycle_outputs", 64'(act_v), 64'(exp_v));
        // event recording
        if (reset) have_frame = 1'b0;
        if (fifo_rd) begin
            rd_cnt++;
            if (have_frame) rd_ph.push_back(cyc - last_fs);
        end
        if (underrun) ur_cnt++;
        if (frame_start) begin
            if (have_frame) begin cap_d.push_back(cur_d); cap_w.push_back(cur_w); end
            cur_d = '0; cur_w = '0; cur_slot = 0; have_frame = 1'b1;
            fs_t.push_back(cyc); last_fs = cyc;
        end
        if (i2s_bclk && !prev_bclk) begin
            if (br_t.size() < 2) br_t.push_back(cyc);
            if (have_frame && cur_slot < 64) begin
                cur_d[63-cur_slot] = i2s_data;
                cur_w[63-cur_slot] = i2s_wclk;
                cur_slot++;
            end
        end
        if (prev_busy && !busy && have_frame) begin
            cap_d.push_back(cur_d); cap_w.push_back(cur_w); have_frame = 1'b0;
        end
        prev_bclk = i2s_bclk;
        prev_busy = busy;
        // FIFO: head retires after the strobe cycle ends
        if (pop_owed && fifo_q.size() > 0) void'(fifo_q.pop_front());
        pop_owed = fifo_rd;
        upd_pins();
    endtask

    task automatic wait_fs_count(input int target, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (fs_t.size() >= target) break;
            tick();
        end
        check("wait_frame_start", 64'(fs_t.size() >= target), 64'd1);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            tick();
            if (!busy) break;
        end
        check("wait_idle", 64'(busy), 64'd0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        checks = 0; failures = 0; cyc = 0; pop_owed = 1'b0;
        prev_bclk = 1'b0; prev_busy = 1'b0; last_fs = 0;
        cur_d = '0; cur_w = '0;
        reset = 1'b1; enable = 1'b0;
        fifo_q.delete(); upd_pins(); clear_mon();
        repeat (4) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("reset_outputs", 64'({fifo_rd, i2s_bclk, i2s_wclk, i2s_data, busy, frame_start, underrun}), 64'd0);

        // T2 + T5: single word frame, enable dropped in slot 10
        clear_mon();
        fifo_q.push_back(48'hABCDEF_123456);
        fifo_q.push_back(48'h111111_222222);
        upd_pins();
        enable = 1'b1;
        wait_fs_count(1, 40);
        check("t2_prime_rd", 64'(rd_cnt), 64'd1);
        repeat (42) tick();
        enable = 1'b0;
        wait_idle(600);
        check("t2_frames", 64'(cap_d.size()), 64'd1);
        check("t2_data", frame_at(0), 64'hABCD_EF00_1234_5600);
        check("t2_wclk", (cap_w.size() > 0) ? cap_w[0] : 64'hDEAD, 64'h0000_0001_FFFF_FFFE);
        check("t2_bclk_period", 64'((br_t.size() > 1) ? br_t[1] - br_t[0] : 0), 64'd4);
        check("t5_no_fetch_pop", 64'(rd_cnt), 64'd1);
        check("t5_fifo_count", 64'(fifo_q.size()), 64'd1);
        check("t5_underrun", 64'(ur_cnt), 64'd0);
        fifo_q.delete(); upd_pins();
        repeat (5) tick();

        // T3: three queued words, continuous frames
        clear_mon();
        fifo_q.push_back(48'h800001_7FFFFE);
        fifo_q.push_back(48'hA5A5A5_5A5A5A);
        fifo_q.push_back(48'h000F00_F000F0);
        upd_pins();
        enable = 1'b1;
        wait_fs_count(3, 700);
        repeat (42) tick();
        enable = 1'b0;
        wait_idle(600);
        check("t3_frames", 64'(cap_d.size()), 64'd3);
        check("t3_frame1", frame_at(0), 64'h8000_0100_7FFF_FE00);
        check("t3_frame2", frame_at(1), 64'hA5A5_A500_5A5A_5A00);
        check("t3_frame3", frame_at(2), 64'h000F_0000_F000_F000);
        check("t3_rd_cnt", 64'(rd_cnt), 64'd3);
        check("t3_rd_phase1", 64'((rd_ph.size() > 0) ? rd_ph[0] : -1), 64'd224);
        check("t3_rd_phase2", 64'((rd_ph.size() > 1) ? rd_ph[1] : -1), 64'd224);
        check("t3_fs_gap1", 64'((fs_t.size() > 1) ? fs_t[1] - fs_t[0] : 0), 64'd256);
        check("t3_fs_gap2", 64'((fs_t.size() > 2) ? fs_t[2] - fs_t[1] : 0), 64'd256);
        check("t3_underrun", 64'(ur_cnt), 64'd0);
        repeat (5) tick();

        // T4: underrun at frame-1 fetch, recovery in frame 3
        clear_mon();
        fifo_q.push_back(48'h5A5A5A_C3C3C3);
        upd_pins();
        enable = 1'b1;
        wait_fs_count(2, 400);
        repeat (80) tick();
        fifo_q.push_back(48'h13579B_2468AC);
        upd_pins();
        wait_fs_count(3, 300);
        repeat (42) tick();
        enable = 1'b0;
        wait_idle(600);
        check("t4_underrun", 64'(ur_cnt), 64'd1);
        check("t4_rd_cnt", 64'(rd_cnt), 64'd2);
        check("t4_frames", 64'(cap_d.size()), 64'd3);
        check("t4_frame1", frame_at(0), 64'h5A5A_5A00_C3C3_C300);
        check("t4_frame2_zero", frame_at(1), 64'h0);
        check("t4_frame3", frame_at(2), 64'h1357_9B00_2468_AC00);
        repeat (5) tick();

        // T6: enable dropped in slot 60, one more frame follows
        clear_mon();
        fifo_q.push_back(48'hFEDCBA_012345);
        fifo_q.push_back(48'h0F0F0F_F0F0F0);
        upd_pins();
        enable = 1'b1;
        wait_fs_count(1, 40);
        repeat (240) tick();
        enable = 1'b0;
        wait_idle(800);
        check("t6_frames", 64'(cap_d.size()), 64'd2);
        check("t6_frame1", frame_at(0), 64'hFEDC_BA00_0123_4500);
        check("t6_frame2", frame_at(1), 64'h0F0F_0F00_F0F0_F000);
        check("t6_rd_cnt", 64'(rd_cnt), 64'd2);
        repeat (5) tick();

        // T1: reset mid-RUN
        clear_mon();
        fifo_q.push_back(48'hC0FFEE_BADBAD);
        fifo_q.push_back(48'h123123_456456);
        upd_pins();
        enable = 1'b1;
        wait_fs_count(1, 40);
        repeat (100) tick();
        #2;
        reset = 1'b1;
        #1;
        check("t1_async_zero", 64'({fifo_rd, i2s_bclk, i2s_wclk, i2s_data, busy, frame_start, underrun}), 64'd0);
        enable = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (10) tick();
        check("t1_busy_after", 64'(busy), 64'd0);
        check("t1_rd_cnt", 64'(rd_cnt), 64'd1);
        check("t1_fifo_count", 64'(fifo_q.size()), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
